// File: rtl/rv32m_wb_buffer.sv
// Write-back buffer for RV32M results: queues M-unit results for the register
// file and forwards the youngest buffered value for each source register.
module rv32m_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic [31:0]              iIR,
  input  logic                     iVALID,
  input  logic [31:0]              iALU_OUT,
  output logic                     oREADY,
  output logic                     oWB_EN,
  output logic [4:0]               oWB_RD,
  output logic [31:0]              oWB_DATA,
  input  logic                     iWB_ACK,
  input  logic [4:0]               iRS1,
  input  logic [4:0]               iRS2,
  output logic                     oFWD1_HIT,
  output logic                     oFWD2_HIT,
  output logic [31:0]              oFWD1_DATA,
  output logic [31:0]              oFWD2_DATA,
  output logic [$clog2(DEPTH):0]   oCOUNT,
  output logic                     oERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             errSticky;

  logic [4:0]  rdMem   [DEPTH];
  logic [31:0] dataMem [DEPTH];

  logic        isMul;
  logic        pushReq;
  logic        doPush;
  logic        doPop;
  logic        notEmpty;
  logic [32:0] fwd1;
  logic [32:0] fwd2;
  logic        unusedIr;

  assign isMul    = iVALID && (iIR[6:0] == 7'b0110011) && (iIR[31:25] == 7'b0000001);
  assign pushReq  = isMul && (iIR[11:7] != 5'd0);
  assign notEmpty = (count != '0);
  assign oREADY   = (count < CNT_W'(DEPTH));
  assign doPush   = pushReq && oREADY;
  assign doPop    = notEmpty && iWB_ACK;
  assign unusedIr = ^iIR[24:12];

  // Youngest match wins: scan oldest to youngest so later hits overwrite.
  function automatic logic [32:0] fwdLookup(input logic [4:0] rs);
    logic [32:0]      res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (rs != 5'd0) && (rdMem[idx] == rs))
        res = {1'b1, dataMem[idx]};
    end
    return res;
  endfunction

  always_comb begin
    fwd1 = fwdLookup(iRS1);
    fwd2 = fwdLookup(iRS2);
  end

  assign oFWD1_HIT  = fwd1[32];
  assign oFWD1_DATA = fwd1[31:0];
  assign oFWD2_HIT  = fwd2[32];
  assign oFWD2_DATA = fwd2[31:0];

  assign oWB_EN   = notEmpty;
  assign oWB_RD   = notEmpty ? rdMem[head]   : 5'd0;
  assign oWB_DATA = notEmpty ? dataMem[head] : 32'd0;
  assign oCOUNT   = count;
  assign oERR     = errSticky;

  // Control state: pointers, occupancy and sticky overflow flag
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      errSticky <= 1'b0;
    end else begin
      if (doPush) tail <= tail + PTR_W'(1);
      if (doPop)  head <= head + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pushReq && !oREADY) errSticky <= 1'b1;
    end
  end

  // Entry storage: occupancy is tracked by count, so data needs no reset
  always_ff @(posedge iCLK) begin
    if (doPush) begin
      rdMem[tail]   <= iIR[11:7];
      dataMem[tail] <= iALU_OUT;
    end
  end

endmodule

// File: tb/tb_rv32m_wb_buffer.sv
// Directed bench for rv32m_wb_buffer (DEPTH=4) with hand-computed expectations.
module tb_rv32m_wb_buffer;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [31:0] iIR;
  logic        iVALID;
  logic [31:0] iALU_OUT;
  logic        oREADY;
  logic        oWB_EN;
  logic [4:0]  oWB_RD;
  logic [31:0] oWB_DATA;
  logic        iWB_ACK;
  logic [4:0]  iRS1;
  logic [4:0]  iRS2;
  logic        oFWD1_HIT;
  logic        oFWD2_HIT;
  logic [31:0] oFWD1_DATA;
  logic [31:0] oFWD2_DATA;
  logic [2:0]  oCOUNT;
  logic        oERR;

  int nChecks = 0;
  int nErrors = 0;

  rv32m_wb_buffer #(.DEPTH(4)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iIR(iIR), .iVALID(iVALID), .iALU_OUT(iALU_OUT),
    .oREADY(oREADY), .oWB_EN(oWB_EN), .oWB_RD(oWB_RD), .oWB_DATA(oWB_DATA),
    .iWB_ACK(iWB_ACK), .iRS1(iRS1), .iRS2(iRS2),
    .oFWD1_HIT(oFWD1_HIT), .oFWD2_HIT(oFWD2_HIT),
    .oFWD1_DATA(oFWD1_DATA), .oFWD2_DATA(oFWD2_DATA),
    .oCOUNT(oCOUNT), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkM(input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pushM(input logic [4:0] rd, input logic [31:0] data);
    iIR = mkM(rd); iALU_OUT = data; iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
  endtask

  initial begin
    iRST_N = 1'b0; iIR = '0; iVALID = 1'b0; iALU_OUT = '0;
    iWB_ACK = 1'b0; iRS1 = 5'd1; iRS2 = 5'd2;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_ready", 32'(oREADY), 32'd1);
    chk("rst_wb_en", 32'(oWB_EN), 32'd0);
    chk("rst_wb_rd", 32'(oWB_RD), 32'd0);
    chk("rst_wb_data", oWB_DATA, 32'd0);
    chk("rst_count", 32'(oCOUNT), 32'd0);
    chk("rst_err", 32'(oERR), 32'd0);
    chk("rst_fwd1_hit", 32'(oFWD1_HIT), 32'd0);
    chk("rst_fwd1_data", oFWD1_DATA, 32'd0);
    iRST_N = 1'b1;
    tick();

    // rd=x0 MUL is dropped
    iIR = 32'h02208033; iALU_OUT = 32'hDEADBEEF; iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    chk("x0_count", 32'(oCOUNT), 32'd0);
    chk("x0_wb_en", 32'(oWB_EN), 32'd0);

    // rd=x3 push; no same-cycle bypass, no forwarding from the input
    iIR = 32'h022081B3; iALU_OUT = 32'h12345678; iVALID = 1'b1; iRS1 = 5'd3;
    #1;
    chk("nobypass_wb_en", 32'(oWB_EN), 32'd0);
    chk("nofwd_input", 32'(oFWD1_HIT), 32'd0);
    tick();
    iVALID = 1'b0;
    chk("x3_wb_en", 32'(oWB_EN), 32'd1);
    chk("x3_wb_rd", 32'(oWB_RD), 32'd3);
    chk("x3_wb_data", oWB_DATA, 32'h12345678);
    chk("x3_fwd1", oFWD1_DATA, 32'h12345678);
    iWB_ACK = 1'b1;
    tick();
    chk("x3_pop_count", 32'(oCOUNT), 32'd0);
    chk("empty_wb_rd", 32'(oWB_RD), 32'd0);
    chk("empty_wb_data", oWB_DATA, 32'd0);
    // ack while empty is ignored
    tick();
    iWB_ACK = 1'b0;
    chk("empty_ack_count", 32'(oCOUNT), 32'd0);

    // ADD is not an M result
    iIR = 32'h002081B3; iALU_OUT = 32'h55; iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    chk("add_count", 32'(oCOUNT), 32'd0);

    // Fill to DEPTH
    for (int i = 1; i <= 4; i++) pushM(5'(i), 32'h100 + 32'(i));
    chk("full_ready", 32'(oREADY), 32'd0);
    chk("full_count", 32'(oCOUNT), 32'd4);
    iRS1 = 5'd3;
    #1;
    chk("full_fwd_x3", oFWD1_DATA, 32'h103);
    iIR = 32'h002081B3; iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    chk("add_full_err", 32'(oERR), 32'd0);
    pushM(5'd0, 32'h999);
    chk("x0_full_err", 32'(oERR), 32'd0);
    pushM(5'd7, 32'h777);
    chk("ovf_err", 32'(oERR), 32'd1);
    chk("ovf_count", 32'(oCOUNT), 32'd4);
    chk("ovf_head", oWB_DATA, 32'h101);
    iWB_ACK = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_rd", 32'(oWB_RD), 32'(i));
      chk("drain_data", oWB_DATA, 32'h100 + 32'(i));
      tick();
    end
    iWB_ACK = 1'b0;
    chk("drain_ready", 32'(oREADY), 32'd1);
    chk("drain_count", 32'(oCOUNT), 32'd0);
    chk("err_sticky", 32'(oERR), 32'd1);

    // Youngest-match forwarding
    pushM(5'd5, 32'hAAAA);
    pushM(5'd5, 32'hBBBB);
    iRS1 = 5'd5; iRS2 = 5'd0;
    #1;
    chk("fwd1_hit", 32'(oFWD1_HIT), 32'd1);
    chk("fwd1_data", oFWD1_DATA, 32'hBBBB);
    chk("fwd2_hit_x0", 32'(oFWD2_HIT), 32'd0);
    chk("fwd2_data_x0", oFWD2_DATA, 32'd0);
    iRS2 = 5'd9;
    #1;
    chk("fwd2_miss", 32'(oFWD2_HIT), 32'd0);

    // Simultaneous push and pop across pointer wrap
    iWB_ACK = 1'b1;
    for (int k = 0; k < 10; k++) begin
      iIR = mkM(5'(8 + k)); iALU_OUT = 32'hC00 + 32'(k); iVALID = 1'b1;
      #1;
      if (k == 0)      chk("pp_head", oWB_DATA, 32'hAAAA);
      else if (k == 1) chk("pp_head", oWB_DATA, 32'hBBBB);
      else             chk("pp_head", oWB_DATA, 32'hC00 + 32'(k - 2));
      tick();
      chk("pp_count", 32'(oCOUNT), 32'd2);
    end
    iVALID = 1'b0; iWB_ACK = 1'b0;
    chk("pp_final_rd", 32'(oWB_RD), 32'd16);
    chk("pp_final_data", oWB_DATA, 32'hC08);

    // Asynchronous reset mid-ack with three entries
    pushM(5'd20, 32'hD00);
    chk("pre_rst_count", 32'(oCOUNT), 32'd3);
    iRS1 = 5'd20;
    iWB_ACK = 1'b1;
    #2;
    iRST_N = 1'b0;
    #1;
    chk("arst_count", 32'(oCOUNT), 32'd0);
    chk("arst_wb_en", 32'(oWB_EN), 32'd0);
    chk("arst_err", 32'(oERR), 32'd0);
    chk("arst_ready", 32'(oREADY), 32'd1);
    chk("arst_fwd1", 32'(oFWD1_HIT), 32'd0);
    tick();
    iRST_N = 1'b1;
    iWB_ACK = 1'b0;
    tick();
    chk("post_rst_wb_en", 32'(oWB_EN), 32'd0);
    chk("post_rst_count", 32'(oCOUNT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/rv32m_wb_buffer.md
RV32M_WB_BUFFER -- requirements
Module: rv32m_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of result entries (power of two, at least 2).
REQ-002 SHALL have port iCLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iIR  input  32  instruction word accompanying the M-unit result.
REQ-005 SHALL have port iVALID  input  1  the M-unit result on iALU_OUT and iIR is valid this cycle.
REQ-006 SHALL have port iALU_OUT  input  32  M-unit result (mul/mulh/div/rem output).
REQ-007 SHALL have port oREADY  output  1  the buffer can accept a push this cycle.
REQ-008 SHALL have port oWB_EN  output  1  the head entry is presented for register-file write.
REQ-009 SHALL have port oWB_RD  output  5  destination register of the head entry.
REQ-010 SHALL have port oWB_DATA  output  32  result of the head entry.
REQ-011 SHALL have port iWB_ACK  input  1  the register file accepted the head entry this cycle.
REQ-012 SHALL have ports iRS1 and iRS2  input  5 each  source registers for the forwarding lookup.
REQ-013 SHALL have ports oFWD1_HIT and oFWD2_HIT  output  1 each  a buffered result matches iRS1 / iRS2.
REQ-014 SHALL have ports oFWD1_DATA and oFWD2_DATA  output  32 each  the matching buffered result.
REQ-015 SHALL have port oCOUNT  output  clog2(DEPTH)+1  number of occupied entries.
REQ-016 SHALL have port oERR  output  1  sticky error flag: an M result arrived while the buffer was full.

Function
REQ-017 SHALL classify an input as an M result when iVALID=1, iIR[6:0]=0110011 and iIR[31:25]=0000001.
REQ-018 SHALL push {iIR[11:7], iALU_OUT} at the tail on the rising edge when the input is an M result, oREADY=1 and iIR[11:7]!=0.
REQ-019 SHALL silently discard M results with rd=x0 and all non-M inputs: no push, no count change.
REQ-020 SHALL drive oREADY = (oCOUNT < DEPTH), combinationally from registered state only.
REQ-021 SHALL drive oWB_EN=1 whenever oCOUNT>0, with oWB_RD/oWB_DATA taken from the head entry.
REQ-022 SHALL drive oWB_RD=0 and oWB_DATA=0 when the buffer is empty.
REQ-023 SHALL pop the head on the rising edge when oWB_EN=1 and iWB_ACK=1; iWB_ACK while empty SHALL be ignored.
REQ-024 SHALL make a pushed entry visible on oWB_* no earlier than the cycle after the push (one-cycle latency, no input-to-output bypass).
REQ-025 SHALL perform push and pop in the same cycle when both conditions hold, leaving oCOUNT unchanged.
REQ-026 SHALL refuse a push while full even if a pop occurs in the same cycle (oREADY depends on state only).
REQ-027 SHALL advance head and tail pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-028 SHALL set oERR on the rising edge when an M result with rd!=0 arrives while oREADY=0; oERR SHALL remain set until reset.
REQ-029 SHALL assert oFWDn_HIT when iRSn!=0 and any occupied entry has rd=iRSn, selecting the youngest matching entry for oFWDn_DATA.
REQ-030 SHALL never forward from the current-cycle input, and SHALL drive oFWDn_DATA=0 when oFWDn_HIT=0.
REQ-031 SHALL keep the forwarding lookup purely combinational from stored entries and iRS1/iRS2.

Reset
REQ-032 SHALL, while iRST_N=0, asynchronously clear head, tail, count and oERR, and invalidate all entries.
REQ-033 SHALL hold these reset values: oREADY=1, oWB_EN=0, oWB_RD=0, oWB_DATA=0, oCOUNT=0, oFWD*_HIT=0, oFWD*_DATA=0, oERR=0.
REQ-034 SHALL discard all buffered entries, including one being pushed or popped, on reset assertion mid-operation; no write is presented after release.

Verification
REQ-035 SHALL test: push MUL (iIR=0x02208033, rd=x0) -> no push, oCOUNT stays 0; push iIR=0x022081B3 (rd=x3), data 0x12345678 -> next cycle oWB_EN=1, oWB_RD=3, oWB_DATA=0x12345678.
REQ-036 SHALL test: fill DEPTH=4 with iWB_ACK=0 -> oREADY=0, oCOUNT=4; a 5th M push -> oERR=1 and contents unchanged; then 4 acks -> data drains in order and oREADY=1.
REQ-037 SHALL test: with 2 entries and push+ack in the same cycle -> oCOUNT stays 2, head advances, tail advances; repeat for 10 cycles to exercise pointer wrap.
REQ-038 SHALL test: entries rd=5/0xAAAA then rd=5/0xBBBB, iRS1=5, iRS2=0 -> oFWD1_HIT=1, oFWD1_DATA=0xBBBB, oFWD2_HIT=0.
REQ-039 SHALL test: iRST_N low asynchronously with 3 entries mid-ack -> oCOUNT=0, oWB_EN=0, oERR=0 immediately, without waiting for a clock edge.
REQ-040 SHALL test: an ADD (iIR[31:25]=0000000) with iVALID=1 -> ignored, no push, oERR unchanged even when full.
